// File: rtl/hilo_unit_ctrl.sv
// HI/LO sequencing controller: owns HI/LO, runs a registered multiply and a
// 32-step restoring divider, and stalls EX while a result is in flight.
module hilo_unit_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_valid,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_req,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   typedef enum logic [2:0] {
      OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
   } op_t;

   state_t      state;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        mul_signed;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [4:0]  count;

   logic        start_mul;
   logic        start_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] product;
   logic [32:0] trial;
   logic [32:0] diff;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] q_final;
   logic [31:0] r_final;
   logic        in_flight;

   assign start_mul = start_valid && (op == OP_MULT || op == OP_MULTU);
   assign start_div = start_valid && (op == OP_DIV || op == OP_DIVU);

   // Signed divides run on magnitudes; -0x80000000 wraps to its own magnitude.
   assign a_neg = (op == OP_DIV) && a[31];
   assign b_neg = (op == OP_DIV) && b[31];
   assign a_mag = a_neg ? (~a + 32'd1) : a;
   assign b_mag = b_neg ? (~b + 32'd1) : b;

   assign ext_a   = mul_signed ? {{32{opa[31]}}, opa} : {32'd0, opa};
   assign ext_b   = mul_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
   assign product = ext_a * ext_b;

   assign trial    = {rem, quo[31]};
   assign diff     = trial - {1'b0, dvs};
   assign rem_next = diff[32] ? trial[31:0] : diff[31:0];
   assign quo_next = {quo[30:0], ~diff[32]};
   assign q_final  = neg_q ? (~quo_next + 32'd1) : quo_next;
   assign r_final  = neg_r ? (~rem_next + 32'd1) : rem_next;

   // The MFHI/MFLO hazard term is subsumed by the in-flight stall but kept explicit.
   assign in_flight = (state == MUL) || (state == DIV);
   assign stall     = !flush && (in_flight || (state == IDLE && (start_mul || start_div))
                                 || (rd_req && in_flight));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         hi         <= 32'd0;
         lo         <= 32'd0;
         count      <= 5'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         opa        <= 32'd0;
         opb        <= 32'd0;
         mul_signed <= 1'b0;
         rem        <= 32'd0;
         quo        <= 32'd0;
         dvs        <= 32'd0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero   <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         count <= 5'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         busy <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_valid && op == OP_MTHI) begin
                  hi <= a;
               end else if (start_valid && op == OP_MTLO) begin
                  lo <= a;
               end else if (start_mul) begin
                  opa        <= a;
                  opb        <= b;
                  mul_signed <= (op == OP_MULT);
                  busy       <= 1'b1;
                  state      <= MUL;
               end else if (start_div) begin
                  opa      <= a;
                  rem      <= 32'd0;
                  quo      <= a_mag;
                  dvs      <= b_mag;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= (b == 32'd0);
                  count    <= 5'd0;
                  busy     <= 1'b1;
                  state    <= DIV;
               end
            end
            MUL: begin
               hi    <= product[63:32];
               lo    <= product[31:0];
               done  <= 1'b1;
               state <= DONE;
            end
            DIV: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  hi    <= div_zero ? opa : r_final;
                  lo    <= div_zero ? 32'hFFFF_FFFF : q_final;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  busy <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit_ctrl.sv
// Directed and randomized bench for hilo_unit_ctrl, checked against an
// arithmetic reference model of HI/LO results and stall latency.
module tb_hilo_unit_ctrl;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start_valid;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_req;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hilo_unit_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .start_valid (start_valid),
      .op          (op),
      .a           (a),
      .b           (b),
      .rd_req      (rd_req),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Results straight from the architectural definition using 64-bit host arithmetic.
   function automatic void refModel(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                                    output logic [31:0] eh, output logic [31:0] el, output int lat);
      longint      sa;
      longint      sb;
      longint      sq;
      longint      sr;
      logic [63:0] p;
      eh  = 32'd0;
      el  = 32'd0;
      lat = 0;
      case (op_v)
         OP_MULT: begin
            sa = $signed(a_v);
            sb = $signed(b_v);
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
            lat = 2;
         end
         OP_MULTU: begin
            p  = {32'd0, a_v} * {32'd0, b_v};
            eh = p[63:32];
            el = p[31:0];
            lat = 2;
         end
         OP_DIV, OP_DIVU: begin
            lat = 33;
            if (b_v == 32'd0) begin
               eh = a_v;
               el = 32'hFFFF_FFFF;
            end else if (op_v == OP_DIVU) begin
               el = a_v / b_v;
               eh = a_v % b_v;
            end else begin
               sa = $signed(a_v);
               sb = $signed(b_v);
               sq = sa / sb;
               sr = sa % sb;
               el = sq[31:0];
               eh = sr[31:0];
            end
         end
         default: lat = 0;
      endcase
   endfunction

   // Issue one mult/div with start_valid held through DONE, as EX would.
   task automatic applyStimulus(input string tag, input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
      logic [31:0] eh;
      logic [31:0] el;
      int lat;
      int stalls = 0;
      int busys  = 0;
      int dones  = 0;
      refModel(op_v, a_v, b_v, eh, el, lat);
      @(negedge clk);
      start_valid = 1'b1;
      op = op_v;
      a  = a_v;
      b  = b_v;
      #1;
      for (int i = 0; i < 100 && stall; i++) begin
         stalls++;
         if (busy) busys++;
         if (done) dones++;
         @(negedge clk);
         #1;
      end
      checkOutput({tag, " stall cycles"}, stalls, lat);
      checkOutput({tag, " busy cycles"}, busys, lat - 1);
      checkOutput({tag, " early done"}, dones, 0);
      checkOutput({tag, " done pulse"}, {31'd0, done}, 32'd1);
      checkOutput({tag, " busy in done"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " hi"}, hi, eh);
      checkOutput({tag, " lo"}, lo, el);
      @(negedge clk);
      start_valid = 1'b0;
      op = OP_NONE;
      #1;
      checkOutput({tag, " no restart busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " done cleared"}, {31'd0, done}, 32'd0);
   endtask

   task automatic moveTo(input string tag, input logic [2:0] op_v, input logic [31:0] a_v, input logic flush_v);
      @(negedge clk);
      start_valid = 1'b1;
      op    = op_v;
      a     = a_v;
      flush = flush_v;
      #1;
      checkOutput({tag, " no stall"}, {31'd0, stall}, 32'd0);
      @(negedge clk);
      start_valid = 1'b0;
      op    = OP_NONE;
      flush = 1'b0;
      #1;
   endtask

   initial begin
      int stalls;
      int dones;
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;

      resetn = 1'b0;
      start_valid = 1'b0;
      op = OP_NONE;
      a = 32'd0;
      b = 32'd0;
      rd_req = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      $display("[TB] reset checks");
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      checkOutput("reset stall", {31'd0, stall}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset done", {31'd0, done}, 32'd0);

      $display("[TB] directed multiply and divide");
      applyStimulus("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2);
      applyStimulus("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      applyStimulus("divu 100/7", OP_DIVU, 32'd100, 32'd7);
      applyStimulus("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      applyStimulus("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus("divu by zero", OP_DIVU, 32'h0000_1234, 32'd0);
      applyStimulus("div by zero", OP_DIV, 32'h8765_4321, 32'd0);

      $display("[TB] flush during divide");
      moveTo("mthi 5", OP_MTHI, 32'd5, 1'b0);
      moveTo("mtlo 5", OP_MTLO, 32'd5, 1'b0);
      checkOutput("preset hi", hi, 32'd5);
      checkOutput("preset lo", lo, 32'd5);
      @(negedge clk);
      start_valid = 1'b1;
      op = OP_DIVU;
      a = 32'd1000;
      b = 32'd3;
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flush cycle stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      start_valid = 1'b0;
      op = OP_NONE;
      #1;
      checkOutput("after flush stall", {31'd0, stall}, 32'd0);
      checkOutput("after flush busy", {31'd0, busy}, 32'd0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         @(negedge clk);
         #1;
      end
      checkOutput("after flush done", dones, 0);
      checkOutput("after flush hi", hi, 32'd5);
      checkOutput("after flush lo", lo, 32'd5);

      moveTo("flushed mthi", OP_MTHI, 32'hDEAD_BEEF, 1'b1);
      checkOutput("flushed mthi hi", hi, 32'd5);

      $display("[TB] read hazard during divide");
      @(negedge clk);
      start_valid = 1'b1;
      op = OP_DIVU;
      a = 32'd50;
      b = 32'd5;
      @(negedge clk);
      start_valid = 1'b0;
      op = OP_NONE;
      rd_req = 1'b1;
      #1;
      stalls = 0;
      for (int i = 0; i < 100 && stall; i++) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      checkOutput("hazard stall cycles", stalls, 32);
      checkOutput("hazard done", {31'd0, done}, 32'd1);
      checkOutput("hazard lo", lo, 32'd10);
      checkOutput("hazard hi", hi, 32'd0);
      rd_req = 1'b0;
      moveTo("mthi a5", OP_MTHI, 32'hA5A5_A5A5, 1'b0);
      checkOutput("mthi a5 hi", hi, 32'hA5A5_A5A5);

      $display("[TB] reset mid-divide");
      @(negedge clk);
      start_valid = 1'b1;
      op = OP_DIV;
      a = 32'd77;
      b = 32'd3;
      @(negedge clk);
      start_valid = 1'b0;
      op = OP_NONE;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      flush = 1'b0;
      #1;
      checkOutput("mid reset hi", hi, 32'd0);
      checkOutput("mid reset lo", lo, 32'd0);
      checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
      checkOutput("mid reset stall", {31'd0, stall}, 32'd0);

      $display("[TB] randomized operations");
      for (int n = 0; n < 16; n++) begin
         r_op = 3'($urandom_range(1, 4));
         r_a  = $urandom;
         case ($urandom_range(0, 5))
            0:       r_b = 32'd0;
            1, 2:    r_b = $urandom_range(1, 20);
            3:       r_b = 32'hFFFF_FFFF;
            default: r_b = $urandom;
         endcase
         applyStimulus($sformatf("rand%0d op%0d", n, r_op), r_op, r_a, r_b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
